// File: rtl/hwpe_stream_split_buffered_if.sv
// hwpe_stream_intf_stream: valid/ready stream with byte strobes.
// Used for both the wide input and the narrow output lanes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );
endinterface

// File: rtl/hwpe_stream_split_buffered.sv
// hwpe_stream_split_buffered: wide stream split into buffered lanes.
// Define HWPE_STREAM_SPLIT_BUFFERED_STATUS_EN for lane_empty_o/stall_cnt_o.
module hwpe_stream_split_buffered #(
  parameter int unsigned DATA_WIDTH_IN  = 128,
  parameter int unsigned NB_OUT_STREAMS = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic [NB_OUT_STREAMS-1:0] lane_mask_i,
  hwpe_stream_intf_stream.sink      push_i,
  hwpe_stream_intf_stream.source    pop_o [NB_OUT_STREAMS]
`ifdef HWPE_STREAM_SPLIT_BUFFERED_STATUS_EN
  ,
  output logic [NB_OUT_STREAMS-1:0] lane_empty_o,
  output logic [15:0]               stall_cnt_o
`endif
);

  localparam int unsigned DW = DATA_WIDTH_IN / NB_OUT_STREAMS;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [NB_OUT_STREAMS-1:0] full;
  logic [NB_OUT_STREAMS-1:0] empty;
  logic [NB_OUT_STREAMS-1:0] enq;
  logic [NB_OUT_STREAMS-1:0] deq;
  logic                      ready;
  logic                      hs;

  // Ready only looks at current full flags: no pass-through on a full lane.
  assign ready = !clear_i && !(|(full & lane_mask_i));
  assign push_i.ready = ready;
  assign hs  = push_i.valid && ready;
  assign enq = hs ? lane_mask_i : '0;

  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_lane
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [DW-1:0] mem_d [FIFO_DEPTH];
    logic [SW-1:0] mem_s [FIFO_DEPTH];

    assign full[i]  = (wptr[AW-1:0] == rptr[AW-1:0])
                   && (wptr[AW] != rptr[AW]);
    assign empty[i] = (wptr == rptr);
    assign deq[i]   = pop_o[i].ready && !empty[i] && !clear_i;

    assign pop_o[i].valid = !empty[i];
    assign pop_o[i].data  = mem_d[rptr[AW-1:0]];
    assign pop_o[i].strb  = mem_s[rptr[AW-1:0]];

    // Pointer update; clear flushes the lane and overrides any handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr <= '0;
        rptr <= '0;
      end else if (clear_i) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (enq[i]) wptr <= wptr + PTR_ONE;
        if (deq[i]) rptr <= rptr + PTR_ONE;
      end
    end

    // Storage; zeroed on reset so the idle head reads as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < FIFO_DEPTH; k++) begin
          mem_d[k] <= '0;
          mem_s[k] <= '0;
        end
      end else if (enq[i]) begin
        mem_d[wptr[AW-1:0]] <= push_i.data[i*DW +: DW];
        mem_s[wptr[AW-1:0]] <= push_i.strb[i*SW +: SW];
      end
    end

    a_no_ovf: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      enq[i] |-> !full[i]);

    a_no_unf: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      deq[i] |-> !empty[i]);
  end

  a_push_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (push_i.valid && !ready) |=>
      (!push_i.valid
       || ($stable(push_i.data) && $stable(push_i.strb))));

`ifdef HWPE_STREAM_SPLIT_BUFFERED_STATUS_EN
  logic [15:0] stall_cnt;

  // Saturating count of cycles where an offered beat is held back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (clear_i) begin
      stall_cnt <= '0;
    end else if (push_i.valid && !ready
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt;
  assign lane_empty_o = empty;
`endif

endmodule

// File: doc/hwpe_stream_split_buffered.md
Name: hwpe_stream_split_buffered

Overview:
Parametrised successor to the combinational stream splitter. It splits one wide HWPE stream into NB_OUT_STREAMS narrow streams, with a per-lane FIFO so each output lane is consumed independently. A runtime lane mask selects which lanes receive data. It sits between a wide streamer/TCDM port and several narrow datapath consumers that drain at different rates.

Parameters:
- DATA_WIDTH_IN, 128, width of the input stream data. Must be divisible by NB_OUT_STREAMS*8.
- NB_OUT_STREAMS, 8, number of output lanes; ≥2.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, ≥2.
- (derived) DATA_WIDTH_OUT = DATA_WIDTH_IN/NB_OUT_STREAMS; STRB_WIDTH_OUT = DATA_WIDTH_OUT/8.

Ports:
- clk_i, input, 1, clock. Single clock domain.
- rst_ni, input, 1, asynchronous active-low reset.
- clear_i, input, 1, synchronous flush of all lanes.
- lane_mask_i, input, NB_OUT_STREAMS, bit i=1 enables lane i.
- push_i, hwpe_stream_intf_stream.sink, DATA_WIDTH_IN, wide input stream (valid/ready/data/strb).
- pop_o[NB_OUT_STREAMS], hwpe_stream_intf_stream.source, DATA_WIDTH_OUT each, narrow output streams.

Behaviour:
- Slicing: lane i takes data[(i+1)*DATA_WIDTH_OUT-1 : i*DATA_WIDTH_OUT] and strb[(i+1)*STRB_WIDTH_OUT-1 : i*STRB_WIDTH_OUT].
- push_i.ready = !clear_i && AND over enabled lanes of !full[i]. It does not depend on push_i.valid.
- Push handshake is push_i.valid && push_i.ready. On a handshake, every lane with lane_mask_i[i]=1 enqueues its slice in that cycle. Disabled lanes enqueue nothing.
- lane_mask_i is sampled only on a handshake cycle. Changing it between beats is legal and does not affect already-queued entries.
- lane_mask_i == 0: push_i.ready=1 (unless clear_i). Accepted beats are discarded.
- Lane FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit.
  - full when the pointer addresses are equal and the wrap bits differ; empty when both are equal.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- pop_o[i].valid = !empty[i]. pop_o[i].data/strb = head entry, which stays stable while valid && !ready.
- Pop handshake: pop_o[i].valid && pop_o[i].ready advances the read pointer. Lanes are fully independent.
- Latency: a beat accepted at cycle N is visible on pop_o at cycle N+1. There is no combinational push-to-pop path.
- Full lane with a same-cycle pop: ready is computed from the current full flag, so no push is accepted that cycle (no pass-through). Ready rises the next cycle.
- Empty lane with a same-cycle push: the pop side sees valid only next cycle.
- clear_i=1:
  - push_i.ready=0 that cycle.
  - All pointers return to 0 at the next edge.
  - All pop_o valid=0 from the next cycle.
  - Any pop or push in the clear cycle is ignored.
- Reset (async, rst_ni=0):
  - Pointers and storage go to 0 immediately.
  - pop_o[*].valid=0, pop_o[*].data=0, pop_o[*].strb=0.
  - push_i.ready = (lane_mask_i≠0 ? 1 : 1) && !clear_i, i.e. 1.
  - Reset mid-operation drops all queued beats.
- Assertions (simulation only, on clk_i while rst_ni=1):
  - push_i data/strb stable while valid && !ready.
  - No enqueue into a full lane.
  - No dequeue from an empty lane.

Optional Feature:
- Macro: HWPE_STREAM_SPLIT_BUFFERED_STATUS_EN.
- Defined: adds two output ports.
  - lane_empty_o [NB_OUT_STREAMS]: equals the per-lane empty flag.
  - stall_cnt_o [16]: counts cycles with push_i.valid && !push_i.ready. It saturates at 16'hFFFF, resets to 0, and is cleared by clear_i.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
- Reset, then push 0x0F0E0D0C_0B0A0908_07060504_03020100, strb all-ones, mask 0xFF, all pop ready=1 → at N+1 each pop_o[i].data = 0x{2i+1}{2i} pattern (lane0=0x0100, lane7=0x0F0E), each valid for exactly 1 cycle.
- Mask 0xFF, pop_o[3].ready=0, others ready=1, push 5 beats → 4 beats accepted, push_i.ready=0 from the 5th. Set pop_o[3].ready=1 → lane3 drains in order 0..3, the 5th beat is accepted one cycle after the first lane3 pop, and lane3 delivers 5 beats total.
- Mask 0x05, push 2 beats → only lanes 0 and 2 ever assert valid, each with 2 entries. Mask 0x00, push 3 beats → ready=1 throughout and no lane asserts valid.
- Fill lane1 to 2 entries, assert clear_i for 1 cycle during a push_i.valid → push not accepted, all valids 0 next cycle. A following push emerges first on all lanes.
- Assert rst_ni=0 asynchronously mid-stream with 3 queued entries → all pop_o valid/data/strb go to 0 before the next edge, push_i.ready=1.
- With HWPE_STREAM_SPLIT_BUFFERED_STATUS_EN: hold lane0 full and push_i.valid=1 for 10 cycles → stall_cnt_o=10, lane_empty_o[0]=0. Pulse clear_i → stall_cnt_o=0, lane_empty_o=all-ones.
